// File: rtl/audio_out_fifo_if.sv
// rtl/audio_out_fifo_if.sv - sample input, codec write port and status bundle for audio_out_fifo
interface audio_out_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 8
);
    localparam int FW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] left_channel_audio_in;
    logic [DATA_WIDTH-1:0] right_channel_audio_in;
    logic                  in_valid;
    logic                  in_ready;
    logic                  write_ready;
    logic                  write;
    logic [DATA_WIDTH-1:0] left_channel_audio_out;
    logic [DATA_WIDTH-1:0] right_channel_audio_out;
    logic [FW-1:0]         fill_level;
    logic [CNT_WIDTH-1:0]  overflow_count;
    logic [CNT_WIDTH-1:0]  underrun_count;
    logic                  priming;

    modport master (
        output left_channel_audio_in, right_channel_audio_in, in_valid, write_ready,
        input  in_ready, write, left_channel_audio_out, right_channel_audio_out,
        input  fill_level, overflow_count, underrun_count, priming
    );

    modport slave (
        input  left_channel_audio_in, right_channel_audio_in, in_valid, write_ready,
        output in_ready, write, left_channel_audio_out, right_channel_audio_out,
        output fill_level, overflow_count, underrun_count, priming
    );
endinterface

// File: rtl/audio_out_fifo.sv
// rtl/audio_out_fifo.sv - stereo pair FIFO feeding the codec DAC with prime/run start-up control
module audio_out_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int PRIME_LEVEL = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    audio_out_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRIME_LVL = (AW+1)'(PRIME_LEVEL);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state_q;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]             fill_q, fill_d;
    logic [CNT_WIDTH-1:0]    ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]    und_q, und_d;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   left_q, right_q;
    logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];

    logic full, empty, run, pop, push, underrun, overflow;

    assign full     = (fill_q == FULL_LVL);
    assign empty    = (fill_q == '0);
    assign run      = (state_q == RUN);
    assign pop      = run && bus.write_ready && !empty;
    assign underrun = run && bus.write_ready && empty;
    // A full FIFO still takes a pair when the head leaves in the same cycle.
    assign push     = bus.in_valid && (!full || pop);
    assign overflow = bus.in_valid && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        ovf_d    = ovf_q;
        und_d    = und_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   fill_d = fill_q + (AW+1)'(1);
            2'b01:   fill_d = fill_q - (AW+1)'(1);
            default: fill_d = fill_q;
        endcase
        if (overflow && (ovf_q != '1)) ovf_d = ovf_q + CNT_WIDTH'(1);
        if (underrun && (und_q != '1)) und_d = und_q + CNT_WIDTH'(1);
    end

    // Sample storage carries no reset; pointers and fill level define validity.
    always_ff @(posedge CLOCK_50) begin
        if (push) mem_q[wr_ptr_q] <= {bus.left_channel_audio_in, bus.right_channel_audio_in};
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q  <= PRIME;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= '0;
            und_q    <= '0;
            write_q  <= 1'b0;
            left_q   <= '0;
            right_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
            und_q    <= und_d;
            write_q  <= pop;
            if (pop) {left_q, right_q} <= mem_q[rd_ptr_q];
            case (state_q)
                PRIME:   if (fill_q >= PRIME_LVL) state_q <= RUN;
                RUN:     if (underrun) state_q <= PRIME;
                default: state_q <= PRIME;
            endcase
        end
    end

    assign bus.in_ready                = !full;
    assign bus.write                   = write_q;
    assign bus.left_channel_audio_out  = left_q;
    assign bus.right_channel_audio_out = right_q;
    assign bus.fill_level              = fill_q;
    assign bus.overflow_count          = ovf_q;
    assign bus.underrun_count          = und_q;
    assign bus.priming                 = (state_q == PRIME);
endmodule

// File: tb/tb_audio_out_fifo.sv
// tb/tb_audio_out_fifo.sv - directed self-checking bench for audio_out_fifo
module tb_audio_out_fifo;
    logic CLOCK_50;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    audio_out_fifo_if #(.DATA_WIDTH(32), .DEPTH(16), .CNT_WIDTH(8)) bus ();

    audio_out_fifo #(
        .DATA_WIDTH(32), .DEPTH(16), .PRIME_LEVEL(4), .CNT_WIDTH(8)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus.slave)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_in(input logic v, input int l, input int r);
        bus.in_valid               = v;
        bus.left_channel_audio_in  = 32'(l);
        bus.right_channel_audio_in = 32'(r);
    endtask

    initial begin
        int exp_l;
        reset           = 1'b0;
        bus.write_ready = 1'b0;
        set_in(1'b0, 0, 0);
        #23;
        chk("rst_fill",     bus.fill_level, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_priming",  bus.priming, 1);
        chk("rst_write",    bus.write, 0);
        chk("rst_left",     bus.left_channel_audio_out, 0);
        chk("rst_right",    bus.right_channel_audio_out, 0);
        chk("rst_ovf",      bus.overflow_count, 0);
        chk("rst_und",      bus.underrun_count, 0);
        @(posedge CLOCK_50);
        #1 reset = 1'b1;

        // prime with four pairs, codec not ready
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, i, 100 + i);
            tick();
        end
        set_in(1'b0, 0, 0);
        chk("t1_fill4",      bus.fill_level, 4);
        chk("t1_still_prime", bus.priming, 1);
        tick();
        chk("t1_run",        bus.priming, 0);
        chk("t1_no_write",   bus.write, 0);

        // drain four pairs back-to-back, then one underrun
        bus.write_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t2_write", bus.write, 1);
            chk("t2_left",  bus.left_channel_audio_out, i);
            chk("t2_right", bus.right_channel_audio_out, 100 + i);
            chk("t2_fill",  bus.fill_level, 4 - i);
        end
        tick();
        chk("t2_und",       bus.underrun_count, 1);
        chk("t2_prime",     bus.priming, 1);
        chk("t2_nowrite",   bus.write, 0);
        chk("t2_hold_l",    bus.left_channel_audio_out, 4);
        chk("t2_hold_r",    bus.right_channel_audio_out, 104);
        bus.write_ready = 1'b0;

        // 17 pushes into 16 slots
        for (int i = 1; i <= 17; i++) begin
            set_in(1'b1, i, 100 + i);
            tick();
            if (i == 16) begin
                chk("t3_in_ready0", bus.in_ready, 0);
                chk("t3_fill16",    bus.fill_level, 16);
            end
        end
        set_in(1'b0, 0, 0);
        chk("t3_ovf1",   bus.overflow_count, 1);
        chk("t3_fill",   bus.fill_level, 16);
        chk("t3_run",    bus.priming, 0);

        // push and pop together while full
        set_in(1'b1, 18, 118);
        bus.write_ready = 1'b1;
        tick();
        set_in(1'b0, 0, 0);
        chk("t4_write",  bus.write, 1);
        chk("t4_left",   bus.left_channel_audio_out, 1);
        chk("t4_right",  bus.right_channel_audio_out, 101);
        chk("t4_fill",   bus.fill_level, 16);
        chk("t4_ovf",    bus.overflow_count, 1);

        // remaining drain: 2..16 then the pair accepted while full
        for (int k = 0; k < 16; k++) begin
            exp_l = (k < 15) ? k + 2 : 18;
            tick();
            chk("t3_drain_write", bus.write, 1);
            chk("t3_drain_left",  bus.left_channel_audio_out, exp_l);
            chk("t3_drain_right", bus.right_channel_audio_out, exp_l + 100);
        end
        tick();
        chk("t3_und2",   bus.underrun_count, 2);
        chk("t3_empty",  bus.fill_level, 0);
        bus.write_ready = 1'b0;

        // overflow counter saturation
        for (int i = 1; i <= 316; i++) begin
            set_in(1'b1, 200 + i, 300 + i);
            tick();
        end
        set_in(1'b0, 0, 0);
        chk("t5_ovf_sat", bus.overflow_count, 255);
        chk("t5_fill",    bus.fill_level, 16);
        set_in(1'b1, 999, 999);
        tick();
        set_in(1'b0, 0, 0);
        chk("t5_ovf_hold", bus.overflow_count, 255);

        // drain to nine pairs, then asynchronous reset between edges
        bus.write_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("t6_left", bus.left_channel_audio_out, 200 + i);
        end
        chk("t6_fill9",  bus.fill_level, 9);
        chk("t6_write",  bus.write, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_write0",   bus.write, 0);
        chk("t6_left0",    bus.left_channel_audio_out, 0);
        chk("t6_right0",   bus.right_channel_audio_out, 0);
        chk("t6_fill0",    bus.fill_level, 0);
        chk("t6_priming",  bus.priming, 1);
        chk("t6_in_ready", bus.in_ready, 1);
        chk("t6_ovf0",     bus.overflow_count, 0);
        tick();
        chk("t6_stay_quiet", bus.write, 0);
        bus.write_ready = 1'b0;
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
